// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch unit bus: ROM port, decoder handshake and LUT write port
interface instr_fetch_if #(
  parameter int PC_W = 8
);
  // Instruction ROM port
  logic [PC_W-1:0] rom_addr;
  logic [8:0]      rom_data;

  // Control decoder handshake
  logic [8:0]      inst;
  logic            branch_en;
  logic            fetch_acc_en;
  logic [7:0]      acc_const;

  // Lookup-table write port
  logic            lut_we;
  logic            lut_sel;
  logic [4:0]      lut_addr;
  logic [7:0]      lut_wdata;

  // Fetch unit side
  modport master (
    output rom_addr,
    output inst,
    output acc_const,
    input  rom_data,
    input  branch_en,
    input  fetch_acc_en,
    input  lut_we,
    input  lut_sel,
    input  lut_addr,
    input  lut_wdata
  );

  // ROM / decoder / loader side
  modport slave (
    input  rom_addr,
    input  inst,
    input  acc_const,
    output rom_data,
    output branch_en,
    output fetch_acc_en,
    output lut_we,
    output lut_sel,
    output lut_addr,
    output lut_wdata
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC sequencer, instruction presenter and branch/acc key lookup for the 9-bit core
module instr_fetch #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  instr_fetch_if.master    bus,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [8:0]       HALT_OP = 9'h1FF;
  localparam logic [8:0]       NOP_OP  = 9'h1A0;
  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0]  PC_MAX  = {PC_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [8:0]      inst_w;

  logic [PC_W-1:0] branch_lut [32];
  logic [7:0]      acc_lut    [32];

  logic            is_halt;
  logic [PC_W-1:0] branch_target;

  assign is_halt       = (bus.rom_data == HALT_OP);
  assign branch_target = branch_lut[bus.rom_data[4:0]];
  assign bus.rom_addr  = pc;

  // Outside RUN the decoder sees an unused opcode so it stays quiet
  always_comb begin
    inst_w = NOP_OP;
    if (state == RUN) begin
      inst_w = bus.rom_data;
    end
  end

  assign bus.inst      = inst_w;
  assign bus.acc_const = bus.fetch_acc_en ? acc_lut[inst_w[4:0]] : 8'h00;

  // Sequencer: state, PC, cycle counter and the registered busy/done flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      cycle_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            pc          <= '0;
            cycle_count <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end
        RUN: begin
          if (cycle_count != CNT_MAX) begin
            cycle_count <= cycle_count + CNT_ONE;
          end
          if (is_halt) begin
            // Halt wins over a branch decoded from the same word; PC parks here
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (bus.branch_en) begin
            pc <= branch_target;
          end else if (pc == PC_MAX) begin
            // Falling off the end of the program stops instead of wrapping
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            pc <= pc + PC_ONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Lookup tables: cleared on reset, writable only while not running
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        branch_lut[i] <= '0;
        acc_lut[i]    <= '0;
      end
    end else if (bus.lut_we && (state != RUN)) begin
      if (bus.lut_sel) begin
        acc_lut[bus.lut_addr] <= bus.lut_wdata;
      end else begin
        branch_lut[bus.lut_addr] <= bus.lut_wdata[PC_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch with ROM and decoder models
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] cycle_count;

  logic [8:0]  rom [256];

  instr_fetch_if #(.PC_W(8)) bus_if ();

  instr_fetch #(.PC_W(8), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bus         (bus_if),
    .busy        (busy),
    .done        (done),
    .cycle_count (cycle_count)
  );

  // ROM and decoder models: 1011xxxxx = branch key, 1100xxxxx = ACC key
  assign bus_if.rom_data     = rom[bus_if.rom_addr];
  assign bus_if.branch_en    = busy && (bus_if.inst[8:5] == 4'b1011);
  assign bus_if.fetch_acc_en = busy && (bus_if.inst[8:5] == 4'b1100);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] acc;
  } step_t;

  typedef struct {
    logic [15:0] cnt;
    logic [7:0]  pc;
  } fin_t;

  step_t step_q[$];
  fin_t  fin_q[$];
  int    checks   = 0;
  int    failures = 0;
  logic  done_d   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_step(input logic [7:0] pc, input logic [7:0] acc);
    step_t s;
    s.pc  = pc;
    s.acc = acc;
    step_q.push_back(s);
  endtask

  task automatic push_fin(input logic [15:0] cnt, input logic [7:0] pc);
    fin_t f;
    f.cnt = cnt;
    f.pc  = pc;
    fin_q.push_back(f);
  endtask

  task automatic fill_rom(input logic [8:0] v);
    for (int i = 0; i < 256; i++) rom[i] = v;
  endtask

  task automatic lut_write(input logic sel, input logic [4:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus_if.lut_we    = 1'b1;
    bus_if.lut_sel   = sel;
    bus_if.lut_addr  = addr;
    bus_if.lut_wdata = data;
    @(negedge clk);
    bus_if.lut_we    = 1'b0;
  endtask

  // Pulse start (plus any LUT write already set up) and wait for done
  task automatic go(input int limit, output int n);
    @(negedge clk);
    start = 1'b1;
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0;
        bus_if.lut_we = 1'b0;
      end
      if (done) break;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic wait_empty(input int limit);
    int k;
    k = 0;
    while (k < limit) begin
      @(negedge clk);
      #1;
      start = 1'b0;
      bus_if.lut_we = 1'b0;
      if (step_q.size() == 0) break;
      k++;
    end
    if (step_q.size() != 0) check("drain_timeout", step_q.size(), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every RUN cycle consumes one expected step, every done rise one finish record
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) begin
        if (step_q.size() == 0) begin
          check("unexpected_run_cycle_pc", {24'h0, bus_if.rom_addr}, 32'hFFFF_FFFF);
        end else begin
          step_t s;
          s = step_q.pop_front();
          check("run_pc", {24'h0, bus_if.rom_addr}, {24'h0, s.pc});
          check("run_acc_const", {24'h0, bus_if.acc_const}, {24'h0, s.acc});
        end
      end
      if (done && !done_d) begin
        if (fin_q.size() == 0) begin
          check("unexpected_done_cycles", {16'h0, cycle_count}, 32'hFFFF_FFFF);
        end else begin
          fin_t f;
          f = fin_q.pop_front();
          check("done_cycle_count", {16'h0, cycle_count}, {16'h0, f.cnt});
          check("done_pc", {24'h0, bus_if.rom_addr}, {24'h0, f.pc});
        end
      end
    end
    done_d = done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    reset            = 1'b1;
    start            = 1'b0;
    bus_if.lut_we    = 1'b0;
    bus_if.lut_sel   = 1'b0;
    bus_if.lut_addr  = 5'd0;
    bus_if.lut_wdata = 8'd0;
    fill_rom(9'h010);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_state", {bus_if.rom_addr, bus_if.inst, busy, done, cycle_count[4:0]},
            {8'h00, 9'h1A0, 1'b0, 1'b0, 5'd0});
    end
    check("idle_cycle_count", {16'h0, cycle_count}, 0);

    // Straight-line run ending on halt at 4
    fill_rom(9'h010);
    rom[0] = 9'h001; rom[1] = 9'h002; rom[2] = 9'h003; rom[3] = 9'h004; rom[4] = 9'h1FF;
    for (int i = 0; i < 5; i++) push_step(8'(i), 8'h00);
    push_fin(16'd5, 8'h04);
    go(40, n);
    check("done_latency", n, 6);
    repeat (2) @(negedge clk);
    check("done_hold", {bus_if.rom_addr, done, busy, bus_if.inst}, {8'h04, 1'b1, 1'b0, 9'h1A0});
    check("done_hold_count", {16'h0, cycle_count}, 5);

    // Branch: LUT write on the same edge as start, then branch key 3 -> 0x10
    fill_rom(9'h010);
    rom[0] = 9'h163; rom[8'h10] = 9'h1FF;
    push_step(8'h00, 8'h00);
    push_step(8'h10, 8'h00);
    push_fin(16'd2, 8'h10);
    bus_if.lut_we = 1'b1; bus_if.lut_sel = 1'b0; bus_if.lut_addr = 5'd3; bus_if.lut_wdata = 8'h10;
    go(40, n);

    // ACC lookup, with a write attempted mid-run that must be dropped
    lut_write(1'b1, 5'd7, 8'hA5);
    fill_rom(9'h010);
    rom[0] = 9'h187; rom[4] = 9'h1FF;
    for (int r = 0; r < 2; r++) begin
      push_step(8'h00, 8'hA5);
      for (int i = 1; i < 5; i++) push_step(8'(i), 8'h00);
      push_fin(16'd5, 8'h04);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus_if.lut_we = 1'b1; bus_if.lut_sel = 1'b1; bus_if.lut_addr = 5'd7; bus_if.lut_wdata = 8'h00;
    @(negedge clk);
    bus_if.lut_we = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("acc_run_done", {31'h0, done}, 1);
    go(40, n);

    // Run-off: no halt, PC reaches 255 and parks there
    fill_rom(9'h010);
    for (int i = 0; i < 256; i++) push_step(8'(i), 8'h00);
    push_fin(16'd256, 8'hFF);
    go(600, n);
    @(negedge clk);
    check("runoff_hold", {bus_if.rom_addr, done}, {8'hFF, 1'b1});

    // Reset mid-run at PC 5
    fill_rom(9'h010);
    for (int i = 0; i < 6; i++) push_step(8'(i), 8'h00);
    @(negedge clk);
    start = 1'b1;
    wait_empty(40);
    pulse_reset();
    check("abort_state", {bus_if.rom_addr, bus_if.inst, busy, done}, {8'h00, 9'h1A0, 1'b0, 1'b0});
    check("abort_cycle_count", {16'h0, cycle_count}, 0);

    // Cleared branch LUT: key 3 now jumps to 0, giving a 0,1,0,1 loop
    rom[1] = 9'h163;
    push_step(8'h00, 8'h00); push_step(8'h01, 8'h00);
    push_step(8'h00, 8'h00); push_step(8'h01, 8'h00);
    @(negedge clk);
    start = 1'b1;
    wait_empty(40);
    pulse_reset();

    // Fresh run from 0 after reset
    rom[1] = 9'h1FF;
    push_step(8'h00, 8'h00); push_step(8'h01, 8'h00);
    push_fin(16'd2, 8'h01);
    go(40, n);

    repeat (2) @(negedge clk);
    check("steps_left", step_q.size(), 0);
    check("fins_left", fin_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Program-sequencing front end of the 9-bit accumulator core.
- Holds the PC and drives the instruction-ROM address.
- Presents the fetched instruction to the control decoder, then consumes the decoder's branch_en and fetch_acc_en.
- Resolves 5-bit branch keys and accumulator keys through two internal 32-entry lookup tables, which are loaded through a write port while idle; also sequences start/halt/done for the testbench and top level.

Parameters:
- PC_W, 8, PC width; the program holds up to 2^PC_W instructions.
- CNT_W, 16, cycle-counter width.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin execution at PC 0; sampled only in IDLE or DONE
- rom_data  input  9  instruction at rom_addr; combinational ROM, valid same cycle
- branch_en  input  1  from control decoder; take branch this cycle
- fetch_acc_en  input  1  from control decoder; current instruction is ACC
- lut_we  input  1  LUT write strobe
- lut_sel  input  1  0 = branch LUT, 1 = acc LUT
- lut_addr  input  5  LUT entry index
- lut_wdata  input  8  LUT write data; branch LUT stores the low PC_W bits
- rom_addr  output  PC_W  current PC
- inst  output  9  instruction to control decoder
- acc_const  output  8  accumulator constant for ACC instructions
- busy  output  1  high in RUN
- done  output  1  high in DONE
- cycle_count  output  CNT_W  number of RUN cycles in the last/current run

Behaviour:
- Reset state, applied on the clk edge with reset=1:
  - state=IDLE, PC=0, cycle_count=0, busy=0, done=0.
  - All 64 LUT entries cleared to 0.
  - Reset mid-RUN aborts the run with no further PC update.
- States: IDLE, RUN, DONE.
  - busy = (state==RUN); done = (state==DONE).
- inst is combinational:
  - RUN: inst = rom_data.
  - IDLE/DONE: inst = 9'h1A0, an unused opcode that makes the decoder assert nothing.
- acc_const is combinational: acc_lut[inst[4:0]] when fetch_acc_en=1, else 0.
- rom_addr = PC at all times.
- IDLE:
  - start=1 -> RUN next cycle; PC=0; cycle_count=0.
  - Otherwise hold.
- RUN, each cycle:
  - cycle_count increments, saturating at all-ones.
  - Halt: rom_data == 9'h1FF -> DONE next cycle. PC holds at the halt address. branch_en is ignored that cycle. The halt cycle is counted.
  - Else if branch_en=1: PC <= branch_lut[rom_data[4:0]].
  - Else if PC == all-ones: run-off -> DONE; PC holds; no wrap to 0.
  - Else PC <= PC+1.
- DONE:
  - Hold PC and cycle_count.
  - start=1 -> RUN next cycle with PC=0 and cycle_count=0; done drops the same edge.
- LUT writes:
  - Performed on the clk edge when lut_we=1 and state != RUN.
  - Ignored entirely in RUN.
  - A write in IDLE on the same cycle as start is performed, then RUN begins.
  - Branch LUT keeps lut_wdata[PC_W-1:0].
- Latency:
  - PC change visible one cycle after the deciding instruction.
  - No delay slots; one instruction per cycle.
- start held high continuously: after a run ends, re-launches one cycle after entering DONE. done is high for exactly one cycle.

Test Plan:
- Reset, then IDLE with no start -> rom_addr=0, inst=9'h1A0, busy=0, done=0, cycle_count=0 for 10 cycles.
- Straight-line run: ROM[0..3] = ALU ops, ROM[4] = 9'h1FF; pulse start.
  - Required: rom_addr steps 0,1,2,3,4, then holds 4.
  - done=1 on the 6th cycle after start; cycle_count=5.
- Branch resolution: branch_lut[3]=8'h10 loaded in IDLE; ROM[0] = unconditional branch key 3 (9'h163); decoder drives branch_en.
  - Required: rom_addr=0x10 next cycle.
  - ROM[0x10] = 9'h1FF -> DONE with cycle_count=2.
- ACC lookup: acc_lut[7]=8'hA5; ROM[0] = 9'h187 with fetch_acc_en=1.
  - Required: acc_const=8'hA5 that cycle, 0 the next.
  - An lut_we writing acc_lut[7]=8'h00 during RUN is ignored; a re-run still yields 8'hA5.
- Run-off: ROM full of non-halt, non-branch ops.
  - Required: PC reaches 255, then DONE with PC held at 255; cycle_count=256.
- Reset mid-run at PC=5 -> next cycle IDLE, PC=0, branch_lut entries read 0; start again runs from 0.
